// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Multi-cycle execution stage replacing the combinational 4-op ALU.
//   ADD/SUB complete in one cycle. MUL runs as shift-add and DIV as restoring
//   division, both one iteration per cycle. Requests arrive over In_valid/In_ready
//   and registered results leave over Out_valid/Out_ready.
//
// Optional feature (macro ALU_SEQ_ACC_EN):
//   Adds an accumulator that captures Result on every output handshake, plus
//   the Acc_sel port. With Acc_sel=1 at accept, the accumulator replaces A.
//   Without the macro there is no accumulator and no Acc_sel port.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   In_valid   in   upstream request valid
//   In_ready   out  unit can accept (IDLE and Reset low)
//   A, B       in   WIDTH-bit unsigned operands
//   Opcode     in   00 ADD, 01 SUB, 10 MUL, 11 DIV
//   Cin        in   carry-in, ADD only
//   Acc_sel    in   accumulator select for A (ALU_SEQ_ACC_EN only)
//   Out_valid  out  Result/flags valid
//   Out_ready  in   downstream accepts result
//   Result     out  sum / difference / product low / quotient
//   Result_hi  out  product high (MUL), remainder (DIV), 0 otherwise
//   Cout       out  carry out (ADD), no-borrow (SUB), |Result_hi (MUL), 0 (DIV)
//   OF         out  signed overflow (ADD/SUB), 0 otherwise
//   Div0       out  DIV with B==0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, In_ready=1
// ALU   | single-cycle ADD/SUB, loads the output registers
// MUL   | WIDTH shift-add iterations, then loads the output registers
// DIV   | WIDTH restoring iterations (none when B==0), then loads outputs
// DONE  | Out_valid=1, outputs held until Out_ready

module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Opcode,
  input  logic             Cin,
`ifdef ALU_SEQ_ACC_EN
  input  logic             Acc_sel,
`endif
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_hi,
  output logic             Cout,
  output logic             OF,
  output logic             Div0
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             cin_r;

  // Iteration down-counter, finished at terminal count zero
  logic [CW-1:0]    cnt;
  logic             cnt_tc;

  // Shared MUL/DIV working pair:
  //   MUL: work_hi = partial product high, work_lo = multiplier shifting out
  //   DIV: work_hi = partial remainder,    work_lo = dividend in / quotient out
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             accept;
  logic [WIDTH-1:0] a_src;

  assign accept = In_valid && In_ready;
  assign cnt_tc = (cnt == '0);

  // ---------------------------------------------------------------
  // Operand A source
  // ---------------------------------------------------------------
`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc_r;

  assign a_src = Acc_sel ? acc_r : A;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r <= '0;
    end else if (Out_valid && Out_ready) begin
      acc_r <= Result;
    end
  end
`else
  assign a_src = A;
`endif

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (Opcode)
            OP_MUL:  state_nxt = S_MUL;
            OP_DIV:  state_nxt = S_DIV;
            default: state_nxt = S_ALU;
          endcase
        end
      end
      S_ALU: state_nxt = S_DONE;
      S_MUL: begin
        if (cnt_tc) state_nxt = S_DONE;
      end
      S_DIV: begin
        // Divide-by-zero skips the iterations entirely
        if ((b_r == '0) || cnt_tc) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (Out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    In_ready  = (state == S_IDLE) && !Reset;
    Out_valid = (state == S_DONE);
  end

  // ---------------------------------------------------------------
  // Datapath: ADD/SUB
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   alu_sum;
  logic             alu_of;

  always_comb begin
    b_eff   = sub_r ? ~b_r : b_r;
    c_eff   = sub_r | cin_r;
    alu_sum = {1'b0, a_r} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    // Carry-into-MSB XOR carry-out, expressed via operand and sum signs
    alu_of  = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (alu_sum[WIDTH-1] != a_r[WIDTH-1]);
  end

  // ---------------------------------------------------------------
  // Datapath: one shift-add step
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    mul_addend = work_lo[0] ? a_r : '0;
    mul_sum    = {1'b0, work_hi} + {1'b0, mul_addend};
  end

  // ---------------------------------------------------------------
  // Datapath: one restoring-division step
  // ---------------------------------------------------------------
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  logic           div_neg;

  always_comb begin
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_r};
    // Partial remainder is always < B, so a set top bit means the trial went negative
    div_neg   = div_trial[WIDTH];
  end

  // ---------------------------------------------------------------
  // Datapath registers and result registers
  // ---------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      cin_r     <= 1'b0;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      Result    <= '0;
      Result_hi <= '0;
      Cout      <= 1'b0;
      OF        <= 1'b0;
      Div0      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_r     <= a_src;
            b_r     <= B;
            sub_r   <= (Opcode == OP_SUB);
            cin_r   <= Cin;
            cnt     <= CNT_INIT;
            work_hi <= '0;
            work_lo <= (Opcode == OP_MUL) ? B : a_src;
            Div0    <= 1'b0;
          end
        end
        S_ALU: begin
          Result    <= alu_sum[WIDTH-1:0];
          Result_hi <= '0;
          Cout      <= alu_sum[WIDTH];
          OF        <= alu_of;
          Div0      <= 1'b0;
        end
        S_MUL: begin
          if (!cnt_tc) begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
            cnt     <= cnt - 1'b1;
          end else begin
            Result    <= work_lo;
            Result_hi <= work_hi;
            Cout      <= |work_hi;
            OF        <= 1'b0;
            Div0      <= 1'b0;
          end
        end
        S_DIV: begin
          if (b_r == '0) begin
            Result    <= '1;
            Result_hi <= a_r;
            Cout      <= 1'b0;
            OF        <= 1'b0;
            Div0      <= 1'b1;
          end else if (!cnt_tc) begin
            if (div_neg) begin
              work_hi <= div_shift[WIDTH-1:0];
              work_lo <= {work_lo[WIDTH-2:0], 1'b0};
            end else begin
              work_hi <= div_trial[WIDTH-1:0];
              work_lo <= {work_lo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt - 1'b1;
          end else begin
            Result    <= work_lo;
            Result_hi <= work_hi;
            Cout      <= 1'b0;
            OF        <= 1'b0;
            Div0      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic       Clk;
  logic       Reset;
  logic       In_valid;
  logic       In_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] Opcode;
  logic       Cin;
  logic       acc_sel_drv;
  logic       Out_valid;
  logic       Out_ready;
  logic [3:0] Result;
  logic [3:0] Result_hi;
  logic       Cout;
  logic       OF;
  logic       Div0;

  alu_seq_unit #(.WIDTH(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .Cin       (Cin),
`ifdef ALU_SEQ_ACC_EN
    .Acc_sel   (acc_sel_drv),
`endif
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Result    (Result),
    .Result_hi (Result_hi),
    .Cout      (Cout),
    .OF        (OF),
    .Div0      (Div0)
  );

  typedef struct {
    logic [3:0] res;
    logic [3:0] hi;
    logic       cout;
    logic       of;
    logic       div0;
    int         first_cyc;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   tag_n = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake
  initial begin
    exp_t e;
    logic ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        ov_prev = 1'b0;
      end else begin
        if (Out_valid) begin
          if (sb.size() == 0) begin
            if (!ov_prev) chk("unexpected_out_valid", 32'(sb.size()), 32'd1);
          end else begin
            e = sb[0];
            if (!ov_prev) chk($sformatf("latency#%0d", e.tag), 32'(cyc), 32'(e.first_cyc));
            chk($sformatf("result#%0d", e.tag),    32'(Result),    32'(e.res));
            chk($sformatf("result_hi#%0d", e.tag), 32'(Result_hi), 32'(e.hi));
            chk($sformatf("cout#%0d", e.tag),      32'(Cout),      32'(e.cout));
            chk($sformatf("of#%0d", e.tag),        32'(OF),        32'(e.of));
            chk($sformatf("div0#%0d", e.tag),      32'(Div0),      32'(e.div0));
            chk($sformatf("in_ready_done#%0d", e.tag), 32'(In_ready), 32'd0);
            if (Out_ready) void'(sb.pop_front());
          end
        end
        ov_prev = Out_valid;
      end
    end
  end

  // Drives one request; returns 1 ns after the accept edge
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic c, input logic push,
                      input logic [3:0] er, input logic [3:0] eh,
                      input logic ec, input logic eo, input logic ed, input int lat);
    exp_t e;
    int t;
    t = 0;
    @(posedge Clk);
    #1;
    A = a; B = b; Opcode = op; Cin = c; In_valid = 1'b1;
    while (!In_ready && t < 50) begin
      @(posedge Clk);
      #1;
      t++;
    end
    if (!In_ready) begin
      chk("accept_timeout", 32'(In_ready), 32'd1);
      In_valid = 1'b0;
      return;
    end
    if (push) begin
      e.res = er; e.hi = eh; e.cout = ec; e.of = eo; e.div0 = ed;
      e.first_cyc = cyc + lat;
      e.tag = tag_n;
      sb.push_back(e);
    end
    tag_n++;
    @(posedge Clk);
    #1;
    // Scramble inputs after acceptance; the unit must ignore them
    In_valid = 1'b0; A = ~a; B = ~b; Cin = ~c;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!In_ready && t < 50) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk("idle_timeout", 32'(In_ready), 32'd1);
  endtask

  initial begin
    int t;
    Reset = 1'b1; In_valid = 1'b0; Out_ready = 1'b1;
    A = '0; B = '0; Opcode = '0; Cin = 1'b0; acc_sel_drv = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready",  32'(In_ready),  32'd0);
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_result",    32'(Result),    32'd0);
    chk("rst_result_hi", 32'(Result_hi), 32'd0);
    chk("rst_flags",     32'({Cout, OF, Div0}), 32'd0);
    Reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(In_ready), 32'd1);

    //    A        B        op     Cin  push  Result   Res_hi   Cout  OF    Div0  lat
    send(4'b0111, 4'b0001, 2'b00, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 2);
    send(4'b0011, 4'b0101, 2'b01, 1'b1, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0, 2);
    send(4'b0101, 4'b0011, 2'b01, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    send(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    send(4'b1000, 4'b1000, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2);
    send(4'b1000, 4'b0001, 2'b01, 1'b0, 1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0, 2);
    send(4'b1111, 4'b1111, 2'b10, 1'b0, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, 6);
    send(4'b0011, 4'b0101, 2'b10, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 6);
    send(4'b1101, 4'b0011, 2'b11, 1'b0, 1'b1, 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0, 6);
    send(4'b0111, 4'b1000, 2'b11, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0, 6);
    send(4'b1001, 4'b0000, 2'b11, 1'b0, 1'b1, 4'b1111, 4'b1001, 1'b0, 1'b0, 1'b1, 2);
    wait_idle();

    // Div0 clears at accept; Result_hi keeps the previous value mid-operation
    send(4'b1111, 4'b0001, 2'b11, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 6);
    chk("div0_cleared_on_accept", 32'(Div0),      32'd0);
    chk("result_hi_held_mid_div", 32'(Result_hi), 32'b1001);
    chk("out_valid_low_mid_div",  32'(Out_valid), 32'd0);
    wait_idle();

    // Backpressure: hold Out_ready low for 3 cycles in DONE
    Out_ready = 1'b0;
    send(4'b0010, 4'b0011, 2'b00, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 2);
    t = 0;
    while (!Out_valid && t < 20) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk("bp_out_valid_seen", 32'(Out_valid), 32'd1);
    repeat (3) begin
      @(posedge Clk);
      #1;
      chk("bp_out_valid_held", 32'(Out_valid), 32'd1);
      chk("bp_in_ready_low",   32'(In_ready),  32'd0);
    end
    Out_ready = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp_release_out_valid", 32'(Out_valid), 32'd0);
    chk("bp_release_in_ready",  32'(In_ready),  32'd1);

    // Reset during the 2nd MUL iteration
    send(4'b1111, 4'b1111, 2'b10, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 6);
    chk("result_held_mid_mul", 32'(Result), 32'b0101);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_in_ready",  32'(In_ready),  32'd0);
    chk("midrst_out_valid", 32'(Out_valid), 32'd0);
    chk("midrst_result",    32'(Result),    32'd0);
    chk("midrst_result_hi", 32'(Result_hi), 32'd0);
    chk("midrst_flags",     32'({Cout, OF, Div0}), 32'd0);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      chk("no_out_valid_after_abort", 32'(Out_valid), 32'd0);
    end
    chk("idle_after_abort", 32'(In_ready), 32'd1);

    send(4'b0001, 4'b0001, 2'b00, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2);

`ifdef ALU_SEQ_ACC_EN
    send(4'b0010, 4'b0011, 2'b00, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 2);
    wait_idle();
    acc_sel_drv = 1'b1;
    send(4'b1111, 4'b0001, 2'b00, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 2);
    acc_sel_drv = 1'b0;
`endif

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge Clk);
      t++;
    end
    @(posedge Clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared, want completion", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
